// File: rtl/vga_capture_640x480.sv
// VGA 640x480 capture: rebuilds pixel coordinates from hsync/vsync edges, locks onto the timing, streams active pixels.
// Optional per-frame CRC-16-CCITT over the pixel stream when VGA_CAPTURE_CRC_EN is defined.
`timescale 1ns/1ps
module vga_capture_640x480 #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 521,
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACT_START = 31,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] red,
  input  logic [2:0] green,
  input  logic [1:0] blue,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [7:0] pix_rgb,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_count
`ifdef VGA_CAPTURE_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t      state, state_next;
  logic [7:0]  good_cnt, good_cnt_next;
  logic        err_inc;

  logic        s_hs, s_vs, s_hs_d, vs_line;
  logic [7:0]  s_rgb;
  logic [9:0]  hcnt, vcnt, cur_h, cur_v;
  logic        seen_line, seen_frame;
  logic        hs_fall, frame_edge, bad_line, bad_frame;
  logic [10:0] line_len, frame_len;
  logic        pix_hit;

  // cur_h/cur_v are the coordinates of the sample currently in s_*; hcnt/vcnt hold the previous sample's.
  always_comb begin
    hs_fall    = s_hs_d & ~s_hs;
    frame_edge = hs_fall & vs_line & ~s_vs;
    line_len   = {1'b0, hcnt} + 11'd1;
    frame_len  = {1'b0, vcnt} + 11'd1;
    bad_line   = hs_fall & seen_line & (line_len != 11'(H_TOTAL));
    bad_frame  = frame_edge & seen_frame & (frame_len != 11'(V_TOTAL));
    cur_h      = hs_fall ? 10'd0 : ((hcnt == 10'h3FF) ? hcnt : hcnt + 10'd1);
    if (frame_edge)
      cur_v = 10'd0;
    else if (hs_fall)
      cur_v = (vcnt == 10'h3FF) ? vcnt : vcnt + 10'd1;
    else
      cur_v = vcnt;
  end

  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    err_inc       = 1'b0;
    unique case (state)
      UNLOCKED: begin
        if (frame_edge && !bad_line && !bad_frame) begin
          state_next    = ACQUIRE;
          good_cnt_next = 8'd0;
        end
      end
      ACQUIRE: begin
        if (bad_line || bad_frame) begin
          state_next = UNLOCKED;
        end else if (frame_edge) begin
          good_cnt_next = good_cnt + 8'd1;
          if (good_cnt_next == 8'(LOCK_FRAMES))
            state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (bad_line || bad_frame) begin
          state_next = UNLOCKED;
          err_inc    = 1'b1;
        end
      end
      default: state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= UNLOCKED;
      good_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
    end
  end

  // Using state_next makes pix_valid and locked drop on the same cycle.
  always_comb begin
    pix_hit = (state_next == LOCKED) &&
              (cur_h >= 10'(H_ACT_START)) && (cur_h < 10'(H_ACT_START + H_ACTIVE)) &&
              (cur_v >= 10'(V_ACT_START)) && (cur_v < 10'(V_ACT_START + V_ACTIVE));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s_hs        <= 1'b1;
      s_vs        <= 1'b1;
      s_hs_d      <= 1'b1;
      vs_line     <= 1'b1;
      s_rgb       <= 8'd0;
      hcnt        <= 10'd0;
      vcnt        <= 10'd0;
      seen_line   <= 1'b0;
      seen_frame  <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      err_count   <= 8'd0;
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 8'd0;
    end else begin
      s_hs        <= hsync;
      s_vs        <= vsync;
      s_rgb       <= {red, green, blue};
      s_hs_d      <= s_hs;
      hcnt        <= cur_h;
      vcnt        <= cur_v;
      if (hs_fall) begin
        vs_line   <= s_vs;
        seen_line <= 1'b1;
      end
      if (frame_edge)
        seen_frame <= 1'b1;
      locked      <= (state_next == LOCKED);
      frame_start <= frame_edge;
      if (err_inc && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
      pix_valid   <= pix_hit;
      if (pix_hit) begin
        pix_x   <= cur_h - 10'(H_ACT_START);
        pix_y   <= cur_v - 10'(V_ACT_START);
        pix_rgb <= s_rgb;
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i])
        c = {c[14:0], 1'b0} ^ 16'h1021;
      else
        c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  logic [15:0] crc_acc;
  logic        frame_ok;

  // frame_ok stays set only if the capture was locked on every cycle since the last frame edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      crc_acc   <= 16'hFFFF;
      frame_ok  <= 1'b0;
      frame_crc <= 16'd0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= frame_edge & frame_ok & (state_next == LOCKED);
      if (frame_edge) begin
        if (frame_ok && (state_next == LOCKED))
          frame_crc <= crc_acc;
        crc_acc  <= 16'hFFFF;
        frame_ok <= (state_next == LOCKED);
      end else begin
        frame_ok <= frame_ok & (state_next == LOCKED);
        if (pix_hit)
          crc_acc <= crc16_byte(crc_acc, s_rgb);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture_640x480.sv
// Self-checking bench for vga_capture_640x480 using a reduced video mode so full frames stay short.
`timescale 1ns/1ps
module tb_vga_capture_640x480;
  localparam int H_TOTAL     = 40;
  localparam int V_TOTAL     = 21;
  localparam int H_ACT_START = 8;
  localparam int H_ACTIVE    = 24;
  localparam int V_ACT_START = 3;
  localparam int V_ACTIVE    = 14;
  localparam int LOCK_FRAMES = 2;
  localparam int HS_W        = 4;
  localparam int VS_LINES    = 2;
  localparam int N_PIX       = H_ACTIVE * V_ACTIVE;

  // clock / reset
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic hsync = 1'b1, vsync = 1'b1;
  logic [2:0] red = '0, green = '0;
  logic [1:0] blue = '0;
  logic       pix_valid, frame_start, locked;
  logic [9:0] pix_x, pix_y;
  logic [7:0] pix_rgb, err_count;
`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] frame_crc;
  logic        crc_valid;
`endif

  always #5 clk = ~clk;

  vga_capture_640x480 #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_ACT_START(H_ACT_START), .H_ACTIVE(H_ACTIVE),
    .V_ACT_START(V_ACT_START), .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .clr(clr), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked), .err_count(err_count)
`ifdef VGA_CAPTURE_CRC_EN
    , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
  );

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] rgb;
    logic       lck;
    logic       fs;
    logic [7:0] err;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int checks = 0;
  int fails  = 0;

  // reference model: sync events, line/frame lengths and lock status derived from the pin waveform
  logic m_prev_hs = 1'b1, m_vs_line = 1'b1, m_seen_line = 1'b0, m_seen_frame = 1'b0;
  int   m_h = 0, m_v = 0, m_mode = 0, m_good = 0, m_err = 0;

  // driver tasks
  task automatic step(input logic c, input logic hs, input logic vs, input logic [7:0] rgb);
    exp_t e;
    logic fall, fedge, bad;
    @(negedge clk);
    clr = c; hsync = hs; vsync = vs; {red, green, blue} = rgb;
    e = '0;
    if (c) begin
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
      m_prev_hs = 1'b1; m_vs_line = 1'b1; m_seen_line = 1'b0; m_seen_frame = 1'b0;
      m_h = 0; m_v = 0; m_mode = 0; m_good = 0; m_err = 0;
    end else begin
      fall  = m_prev_hs && !hs;
      fedge = fall && m_vs_line && !vs;
      bad   = 1'b0;
      if (fall) begin
        if (m_seen_line && (m_h + 1 != H_TOTAL)) bad = 1'b1;
        m_seen_line = 1'b1;
        m_vs_line   = vs;
        m_h = 0;
        if (fedge) begin
          if (m_seen_frame && (m_v + 1 != V_TOTAL)) bad = 1'b1;
          m_seen_frame = 1'b1;
          m_v = 0;
        end else begin
          m_v = m_v + 1;
        end
      end else begin
        m_h = m_h + 1;
      end
      m_prev_hs = hs;
      if (bad) begin
        if (m_mode == 2) m_err = (m_err == 255) ? 255 : m_err + 1;
        m_mode = 0;
      end else if (fedge) begin
        if (m_mode == 0) begin
          m_mode = 1; m_good = 0;
        end else if (m_mode == 1) begin
          m_good = m_good + 1;
          if (m_good == LOCK_FRAMES) m_mode = 2;
        end
      end
      e.valid = (m_mode == 2) && (m_h >= H_ACT_START) && (m_h < H_ACT_START + H_ACTIVE) &&
                (m_v >= V_ACT_START) && (m_v < V_ACT_START + V_ACTIVE);
      e.x   = 10'(m_h - H_ACT_START);
      e.y   = 10'(m_v - V_ACT_START);
      e.rgb = rgb;
      e.lck = (m_mode == 2);
      e.fs  = fedge;
      e.err = 8'(m_err);
    end
    exp_q.push_back(e);
  endtask

  // mode 0 random colour, 1 colour = hc[7:0], 2 constant kval
  task automatic gen_line(input int len, input logic vs, input int mode, input logic [7:0] kval, input int clr_at);
    for (int hc = 0; hc < len; hc++) begin
      logic [7:0] px;
      case (mode)
        0:       px = 8'($urandom_range(0, 255));
        1:       px = 8'(hc);
        default: px = kval;
      endcase
      step(hc == clr_at, hc >= HS_W, vs, px);
    end
  endtask

  task automatic gen_frame(input int lines, input int short_line, input int mode, input logic [7:0] kval,
                           input int clr_line, input int clr_at);
    for (int vc = 0; vc < lines; vc++)
      gen_line((vc == short_line) ? H_TOTAL - 1 : H_TOTAL, vc >= VS_LINES, mode, kval,
               (vc == clr_line) ? clr_at : -1);
  endtask

  // scoreboard and monitor statistics
  int cyc = 0, n_valid = 0, n_fs = 0, lock_rise_cyc = -1, n_crc = 0;
  int fs_cyc[$];
  logic lock_prev = 1'b0, got_first = 1'b0, clr_edge;
  logic [9:0] first_x, first_y, last_x, last_y;
  logic [7:0] first_rgb;
  logic [38:0] snap = '1;
  logic [15:0] crc_seen = '0;

  always @(posedge clk) begin
    exp_t e;
    clr_edge = clr;
    #1;
    cyc++;
    if (clr_edge) snap = {pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_count};
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      checks++;
      if (pix_valid !== e.valid || locked !== e.lck || frame_start !== e.fs || err_count !== e.err ||
          (e.valid && (pix_x !== e.x || pix_y !== e.y || pix_rgb !== e.rgb))) begin
        fails++;
        if (fails <= 20)
          $display("FAIL scoreboard cyc=%0d got v=%b x=%0d y=%0d rgb=%h lk=%b fs=%b err=%0d exp v=%b x=%0d y=%0d rgb=%h lk=%b fs=%b err=%0d",
                   cyc, pix_valid, pix_x, pix_y, pix_rgb, locked, frame_start, err_count,
                   e.valid, e.x, e.y, e.rgb, e.lck, e.fs, e.err);
      end
    end
    if (pix_valid) begin
      n_valid++;
      if (!got_first) begin
        first_x = pix_x; first_y = pix_y; first_rgb = pix_rgb; got_first = 1'b1;
      end
      last_x = pix_x; last_y = pix_y;
    end
    if (frame_start) begin n_fs++; fs_cyc.push_back(cyc); end
    if (locked && !lock_prev) lock_rise_cyc = cyc;
    lock_prev = locked;
`ifdef VGA_CAPTURE_CRC_EN
    if (crc_valid) begin n_crc++; crc_seen = frame_crc; end
`endif
  end

  task automatic test_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 8'h00);
    checks++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_pix_valid got=%b exp=0", pix_valid); end
    checks++; if (pix_x !== 10'd0) begin fails++; $display("FAIL reset_pix_x got=%0d exp=0", pix_x); end
    checks++; if (pix_y !== 10'd0) begin fails++; $display("FAIL reset_pix_y got=%0d exp=0", pix_y); end
    checks++; if (pix_rgb !== 8'd0) begin fails++; $display("FAIL reset_pix_rgb got=%h exp=00", pix_rgb); end
    checks++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    checks++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_lock();
    n_fs = 0; fs_cyc.delete(); lock_rise_cyc = -1;
    gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    checks++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_frame1 locked=%b exp=0", locked); end
    gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    checks++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_frame2 locked=%b exp=0", locked); end
    gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    checks++; if (n_fs !== 3) begin fails++; $display("FAIL lock_fs_count got=%0d exp=3", n_fs); end
    checks++;
    if (fs_cyc.size() < 3 || lock_rise_cyc !== fs_cyc[2]) begin
      fails++; $display("FAIL lock_rise_cycle got=%0d exp=cycle of 3rd frame_start (%0d seen)", lock_rise_cyc, fs_cyc.size());
    end
    checks++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_frame3 locked=%b exp=1", locked); end
    checks++; if (err_count !== 8'd0) begin fails++; $display("FAIL lock_err got=%0d exp=0", err_count); end
  endtask

  task automatic test_pixel_stream();
    n_valid = 0; got_first = 1'b0;
    gen_frame(V_TOTAL, -1, 1, 8'h00, -1, -1);
    checks++; if (n_valid !== N_PIX) begin fails++; $display("FAIL pix_count got=%0d exp=%0d", n_valid, N_PIX); end
    checks++; if (first_x !== 10'd0 || first_y !== 10'd0) begin fails++; $display("FAIL pix_first got=(%0d,%0d) exp=(0,0)", first_x, first_y); end
    checks++; if (first_rgb !== 8'(H_ACT_START)) begin fails++; $display("FAIL pix_first_rgb got=%h exp=%h", first_rgb, 8'(H_ACT_START)); end
    checks++;
    if (last_x !== 10'(H_ACTIVE - 1) || last_y !== 10'(V_ACTIVE - 1)) begin
      fails++; $display("FAIL pix_last got=(%0d,%0d) exp=(%0d,%0d)", last_x, last_y, H_ACTIVE - 1, V_ACTIVE - 1);
    end
  endtask

  task automatic test_short_line();
    gen_frame(V_TOTAL, $urandom_range(4, 15), 0, 8'h00, -1, -1);
    checks++; if (locked !== 1'b0) begin fails++; $display("FAIL short_line_unlock locked=%b exp=0", locked); end
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL short_line_err got=%0d exp=1", err_count); end
    gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    checks++; if (locked !== 1'b0) begin fails++; $display("FAIL short_line_early locked=%b exp=0", locked); end
    gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    checks++; if (locked !== 1'b1) begin fails++; $display("FAIL short_line_relock locked=%b exp=1", locked); end
  endtask

  task automatic test_short_frame();
    gen_frame(V_TOTAL - 1, -1, 0, 8'h00, -1, -1);
    checks++; if (locked !== 1'b1) begin fails++; $display("FAIL short_frame_pre locked=%b exp=1", locked); end
    n_valid = 0;
    for (int f = 0; f < 3; f++) gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    checks++; if (err_count !== 8'd2) begin fails++; $display("FAIL short_frame_err got=%0d exp=2", err_count); end
    checks++; if (n_valid !== 0) begin fails++; $display("FAIL short_frame_no_pix got=%0d exp=0", n_valid); end
    checks++; if (locked !== 1'b0) begin fails++; $display("FAIL short_frame_early locked=%b exp=0", locked); end
    gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    checks++; if (locked !== 1'b1) begin fails++; $display("FAIL short_frame_relock locked=%b exp=1", locked); end
  endtask

  task automatic test_clr_mid_frame();
    snap = '1;
    gen_frame(V_TOTAL, -1, 0, 8'h00, $urandom_range(5, 12), $urandom_range(HS_W + 2, H_TOTAL - 2));
    checks++; if (snap !== 39'd0) begin fails++; $display("FAIL clr_outputs got=%h exp=0", snap); end
    checks++; if (err_count !== 8'd0) begin fails++; $display("FAIL clr_err got=%0d exp=0", err_count); end
    gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    checks++; if (locked !== 1'b0) begin fails++; $display("FAIL clr_early locked=%b exp=0", locked); end
    gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    checks++; if (locked !== 1'b1) begin fails++; $display("FAIL clr_relock locked=%b exp=1", locked); end
  endtask

  task automatic test_back_to_back();
    n_valid = 0;
    for (int f = 0; f < 2; f++) gen_frame(V_TOTAL, -1, 0, 8'h00, -1, -1);
    checks++; if (n_valid !== 2 * N_PIX) begin fails++; $display("FAIL b2b_pix_count got=%0d exp=%0d", n_valid, 2 * N_PIX); end
    checks++; if (locked !== 1'b1) begin fails++; $display("FAIL b2b_locked got=%b exp=1", locked); end
  endtask

`ifdef VGA_CAPTURE_CRC_EN
  function automatic logic [15:0] crc_ref(input int n, input logic [7:0] b);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++)
      for (int i = 7; i >= 0; i--)
        c = (c[15] ^ b[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction

  task automatic test_crc();
    logic [15:0] ref_crc;
    ref_crc = crc_ref(N_PIX, 8'hFF);
    gen_frame(V_TOTAL, -1, 2, 8'hFF, -1, -1);
    n_crc = 0;
    gen_frame(V_TOTAL, -1, 2, 8'hFF, -1, -1);
    checks++; if (n_crc !== 1) begin fails++; $display("FAIL crc_pulses got=%0d exp=1", n_crc); end
    checks++; if (crc_seen !== ref_crc) begin fails++; $display("FAIL crc_value got=%h exp=%h", crc_seen, ref_crc); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_pixel_stream();
    test_short_line();
    test_short_frame();
    test_clr_mid_frame();
    test_back_to_back();
`ifdef VGA_CAPTURE_CRC_EN
    test_crc();
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
